// File: rtl/cv32e40p_sleep_sequencer.sv
// Sleep sequencer: owns the core clock-enable decision and orders sleep entry
// (drain, optional timeout) and exit (settle interval) around the core clock gate.
module cv32e40p_sleep_sequencer #(
    parameter int unsigned WAKE_DELAY    = 2,
    parameter int unsigned DRAIN_TIMEOUT = 16
) (
    input  logic       clk_ungated_i,
    input  logic       rst_n,
    input  logic       fetch_enable_i,
    output logic       fetch_enable_o,
    input  logic       wfi_req_i,
    output logic       wfi_ack_o,
    input  logic       busy_i,
    input  logic       wake_i,
    input  logic       debug_req_i,
    output logic       clock_en_o,
    output logic       core_sleep_o,
    output logic       wake_done_o,
    output logic       drain_timeout_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SLEEP = 3'd3,
        ST_WAKE  = 3'd4
    } state_e;

    // Counters are loaded with (length - 1) and run down to zero, so a DRAIN or
    // WAKE phase occupies exactly its nominal number of cycles.
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0] WAKE_LOAD  = 4'(WAKE_DELAY - 1);
    localparam logic       TIMEOUT_EN = (DRAIN_TIMEOUT != 0) ? 1'b1 : 1'b0;

    state_e     state_q;
    logic [7:0] drain_cnt_q;
    logic [3:0] wake_cnt_q;
    logic       fetch_enable_q;
    logic       wfi_ack_q;
    logic       wake_done_q;
    logic       drain_timeout_q;

    // Sequencer state, counters, sticky fetch enable and one-cycle pulses.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_OFF;
            drain_cnt_q     <= 8'd0;
            wake_cnt_q      <= 4'd0;
            fetch_enable_q  <= 1'b0;
            wfi_ack_q       <= 1'b0;
            wake_done_q     <= 1'b0;
            drain_timeout_q <= 1'b0;
        end else begin
            wfi_ack_q       <= 1'b0;
            wake_done_q     <= 1'b0;
            drain_timeout_q <= 1'b0;

            if (fetch_enable_i) begin
                fetch_enable_q <= 1'b1;
            end

            case (state_q)
                ST_OFF: begin
                    if (fetch_enable_i) begin
                        state_q <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (wfi_req_i && !debug_req_i) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= DRAIN_LOAD;
                    end
                end

                // Wake/debug abort sleep entry without an acknowledge.
                ST_DRAIN: begin
                    if (debug_req_i || wake_i) begin
                        state_q <= ST_RUN;
                    end else if (!wfi_req_i) begin
                        state_q <= ST_RUN;
                    end else if (!busy_i) begin
                        state_q   <= ST_SLEEP;
                        wfi_ack_q <= 1'b1;
                    end else if (TIMEOUT_EN && (drain_cnt_q == 8'd0)) begin
                        state_q         <= ST_RUN;
                        drain_timeout_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 8'd1;
                    end
                end

                ST_SLEEP: begin
                    if (wake_i || debug_req_i) begin
                        state_q    <= ST_WAKE;
                        wake_cnt_q <= WAKE_LOAD;
                    end
                end

                ST_WAKE: begin
                    if (wake_cnt_q == 4'd0) begin
                        state_q     <= ST_RUN;
                        wake_done_q <= 1'b1;
                    end else begin
                        wake_cnt_q <= wake_cnt_q - 4'd1;
                    end
                end

                default: begin
                    state_q <= ST_OFF;
                end
            endcase
        end
    end

    // The gate enable and sleep indication are pure decodes of the state register.
    assign clock_en_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_WAKE);
    assign core_sleep_o    = (state_q == ST_SLEEP);
    assign fetch_enable_o  = fetch_enable_q;
    assign wfi_ack_o       = wfi_ack_q;
    assign wake_done_o     = wake_done_q;
    assign drain_timeout_o = drain_timeout_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_cv32e40p_sleep_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic compared each
// cycle against a cycle-accounting behavioural model of the sequencer.
module tb_cv32e40p_sleep_sequencer;

    localparam int WD = 2;
    localparam int DT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fe_i = 1'b0;
    logic       wfi = 1'b0;
    logic       busy = 1'b0;
    logic       wake = 1'b0;
    logic       dbg = 1'b0;
    logic       fe_o, ack_o, clk_en_o, sleep_o, done_o, to_o;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;

    // Model: mode 0=OFF 1=RUN 2=DRAIN 3=SLEEP 4=WAKE, phases counted upwards.
    int m_mode;
    int m_drain_n;
    int m_wake_n;
    bit m_fe, m_ack, m_to, m_done;

    cv32e40p_sleep_sequencer #(.WAKE_DELAY(WD), .DRAIN_TIMEOUT(DT)) dut (
        .clk_ungated_i  (clk),
        .rst_n          (rst_n),
        .fetch_enable_i (fe_i),
        .fetch_enable_o (fe_o),
        .wfi_req_i      (wfi),
        .wfi_ack_o      (ack_o),
        .busy_i         (busy),
        .wake_i         (wake),
        .debug_req_i    (dbg),
        .clock_en_o     (clk_en_o),
        .core_sleep_o   (sleep_o),
        .wake_done_o    (done_o),
        .drain_timeout_o(to_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_drain_n = 0; m_wake_n = 0;
        m_fe = 1'b0; m_ack = 1'b0; m_to = 1'b0; m_done = 1'b0;
    endfunction

    function automatic void model_step();
        m_ack = 1'b0; m_to = 1'b0; m_done = 1'b0;
        if (fe_i) m_fe = 1'b1;
        case (m_mode)
            0: if (fe_i) m_mode = 1;
            1: if (wfi && !dbg) begin m_mode = 2; m_drain_n = 1; end
            2: begin
                if (dbg || wake || !wfi) m_mode = 1;
                else if (!busy) begin m_mode = 3; m_ack = 1'b1; end
                else if (DT != 0 && m_drain_n == DT) begin m_mode = 1; m_to = 1'b1; end
                else m_drain_n++;
            end
            3: if (wake || dbg) begin m_mode = 4; m_wake_n = 1; end
            4: begin
                if (m_wake_n == WD) begin m_mode = 1; m_done = 1'b1; end
                else m_wake_n++;
            end
            default: m_mode = 0;
        endcase
    endfunction

    task automatic compare_all();
        chk("state", int'(state_o), m_mode);
        chk("clock_en", int'(clk_en_o), int'(m_mode == 1 || m_mode == 2 || m_mode == 4));
        chk("core_sleep", int'(sleep_o), int'(m_mode == 3));
        chk("fetch_enable", int'(fe_o), int'(m_fe));
        chk("wfi_ack", int'(ack_o), int'(m_ack));
        chk("drain_timeout", int'(to_o), int'(m_to));
        chk("wake_done", int'(done_o), int'(m_done));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_rst_state", int'(state_o), 0);
        chk("async_rst_clock_en", int'(clk_en_o), 0);
        chk("async_rst_done", int'(done_o), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n_drain, n_ack, n_to, n_wake, n_done, guard;
        model_reset();
        cycle();
        cycle();
        chk("reset_state", int'(state_o), 0);
        chk("reset_fetch_enable", int'(fe_o), 0);
        chk("reset_sleep", int'(sleep_o), 0);
        release_reset();
        cycle();

        // Fetch enable pulse: OFF -> RUN, sticky.
        fe_i = 1'b1;
        cycle();
        fe_i = 1'b0;
        chk("fe_state_run", int'(state_o), 1);
        chk("fe_clock_en", int'(clk_en_o), 1);
        chk("fe_sticky", int'(fe_o), 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("fe_stays", int'(fe_o & clk_en_o), 1);
        end

        // Sleep entry after busy drops on the third DRAIN cycle.
        wfi = 1'b1; busy = 1'b1;
        n_drain = 0; n_ack = 0; guard = 0;
        while (state_o != 3'd3 && guard < 20) begin
            cycle();
            guard++;
            if (state_o == 3'd2) n_drain++;
            if (ack_o) n_ack++;
            if (n_drain == 3) busy = 1'b0;
        end
        wfi = 1'b0;
        chk("sleep_entry_bound", int'(guard < 20), 1);
        chk("sleep_drain_cycles", n_drain, 3);
        chk("sleep_ack_count", n_ack, 1);
        chk("sleep_core_sleep", int'(sleep_o), 1);
        chk("sleep_clock_en", int'(clk_en_o), 0);

        // Long sleep with fetch enable toggling: nothing moves.
        for (int i = 0; i < 50; i++) begin
            fe_i = i[0];
            cycle();
            chk("sleep_hold_state", int'(state_o), 3);
            chk("sleep_hold_ack", int'(ack_o), 0);
        end
        fe_i = 1'b0;

        // Wake: exactly WD WAKE cycles, then RUN with wake_done.
        wake = 1'b1;
        cycle();
        wake = 1'b0;
        n_wake = (state_o == 3'd4) ? 1 : 0;
        n_done = 0; guard = 0;
        while (state_o == 3'd4 && guard < 20) begin
            cycle();
            guard++;
            if (state_o == 3'd4) n_wake++;
            if (done_o) n_done++;
        end
        chk("wake_cycles", n_wake, 2);
        chk("wake_done_count", n_done, 1);
        chk("wake_state_run", int'(state_o), 1);

        // Drain timeout with busy held high.
        wfi = 1'b1; busy = 1'b1;
        n_drain = 0; n_to = 0; n_ack = 0; guard = 0;
        do begin
            cycle();
            guard++;
            if (state_o == 3'd2) n_drain++;
            if (to_o) begin n_to++; wfi = 1'b0; end
            if (ack_o) n_ack++;
        end while (!(state_o == 3'd1 && n_drain > 0) && guard < 30);
        busy = 1'b0; wfi = 1'b0;
        chk("timeout_drain_cycles", n_drain, 4);
        chk("timeout_pulse_count", n_to, 1);
        chk("timeout_no_ack", n_ack, 0);

        // Debug in the same cycle busy falls wins; debug blocks DRAIN in RUN.
        wfi = 1'b1; busy = 1'b1;
        cycle();
        cycle();
        busy = 1'b0; dbg = 1'b1;
        cycle();
        chk("dbg_race_state", int'(state_o), 1);
        chk("dbg_race_no_ack", int'(ack_o), 0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("dbg_blocks_drain", int'(state_o == 3'd2), 0);
        end
        wfi = 1'b0; dbg = 1'b0;
        cycle();

        // Reset in the middle of WAKE.
        wfi = 1'b1; busy = 1'b0;
        cycle();
        cycle();
        wfi = 1'b0; wake = 1'b1;
        cycle();
        wake = 1'b0;
        chk("pre_reset_wake", int'(state_o), 4);
        assert_reset();
        cycle();
        cycle();
        release_reset();
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("post_reset_no_done", int'(done_o), 0);
        end

        // Randomized traffic.
        fe_i = 1'b1;
        cycle();
        for (int i = 0; i < 1500; i++) begin
            fe_i = ($urandom_range(0, 19) == 0);
            wfi  = ($urandom_range(0, 3) != 0);
            busy = ($urandom_range(0, 2) != 0);
            wake = ($urandom_range(0, 7) == 0);
            dbg  = ($urandom_range(0, 15) == 0);
            cycle();
            if ($urandom_range(0, 399) == 0) begin
                assert_reset();
                cycle();
                release_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
